// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus.
// slave = loader side (consumes bytes, drives writes); master = environment.
interface imem_loader_if #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   imem_we;
    logic [INS_ADDRESS-1:0] imem_wa;
    logic [INS_W-1:0]       imem_wd;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_wa, imem_wd
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_wa, imem_wd
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles little-endian 32-bit words from a byte stream and
// writes them to instruction memory at 0,4,8,...; holds the core meanwhile.
// Ports: clk, reset (sync, active-high), load_start, load_count,
//        bus (slave: in_valid/in_data/in_ready, imem_we/imem_wa/imem_wd),
//        core_hold (high while not idle), done (one-cycle completion pulse).
module imem_loader #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic [INS_ADDRESS-2:0] load_count,
    imem_loader_if.slave           bus,
    output logic                   core_hold,
    output logic                   done
);

    localparam int CW = INS_ADDRESS - 1;
    localparam logic [CW-1:0] CAP = CW'(2 ** (INS_ADDRESS - 2));
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [INS_ADDRESS-1:0] ADDR_STEP = INS_ADDRESS'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [INS_ADDRESS-1:0] addr_q, addr_d;
    logic [INS_W-1:0]       word_q, word_d;
    logic [CW-1:0]          eff_cnt;

    // Requests beyond capacity are clamped so the address never wraps.
    assign eff_cnt = (load_count > CAP) ? CAP : load_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        word_d  = word_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    cnt_d   = eff_cnt;
                    addr_d  = '0;
                    idx_d   = '0;
                    state_d = (eff_cnt == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (bus.in_valid) begin
                    word_d[{idx_q, 3'b000} +: 8] = bus.in_data;
                    // 2-bit index wraps back to 0 after the fourth byte.
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_STEP;
                cnt_d   = cnt_q - CNT_ONE;
                state_d = (cnt_q == CNT_ONE) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready = (state_q == S_RECV);
    assign bus.imem_we  = (state_q == S_WRITE);
    assign bus.imem_wa  = addr_q;
    assign bus.imem_wd  = word_q;
    assign core_hold    = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule
